// File: rtl/add_arb_pkg.sv
// add_arb_pkg: shared FSM state type and operand/result widths for add_arbiter
package add_arb_pkg;
    localparam int OPW = 16;
    localparam int RESW = 32;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/add16_unit.sv
// add16_unit: combinational ripple-carry adder; ports a, b (OPW) -> sum (OPW), carry
module add16_unit import add_arb_pkg::*; (
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [OPW-1:0] sum,
    output logic           carry
);
    logic [OPW:0] c;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < OPW; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign carry = c[OPW];
endmodule

// File: rtl/add_arbiter.sv
// add_arbiter: two-requester arbitrated 16-bit adder (RR_EN round-robin/fixed); clock count, async rst; req0/req1 valid/a/b/ready in, res valid/ready/sum/id out, busy; optional grant_cnt0/1 under ADD_ARBITER_STATS_EN
module add_arbiter import add_arb_pkg::*; #(
    parameter int RR_EN = 1
) (
    input  logic            count,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic [OPW-1:0]  req0_a,
    input  logic [OPW-1:0]  req0_b,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [OPW-1:0]  req1_a,
    input  logic [OPW-1:0]  req1_b,
    output logic            req1_ready,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [RESW-1:0] res_sum,
    output logic            res_id,
    output logic            busy
`ifdef ADD_ARBITER_STATS_EN
    ,
    output logic [15:0]     grant_cnt0,
    output logic [15:0]     grant_cnt1
`endif
);
    state_t         state;
    logic           prio;
    logic           id_q;
    logic           gnt1;
    logic           co;
    logic [OPW-1:0] a_q;
    logic [OPW-1:0] b_q;
    logic [OPW-1:0] s;
    // prio=1 means requester 1 wins a tie; it only ever gets set in round-robin mode
    assign gnt1       = req1_valid & (~req0_valid | prio);
    assign req0_ready = ~rst & (state == IDLE) & req0_valid & ~gnt1;
    assign req1_ready = ~rst & (state == IDLE) & gnt1;
    add16_unit u_add (.a(a_q), .b(b_q), .sum(s), .carry(co));
    always_ff @(posedge count or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= 1'b0;
            id_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_id    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0_valid | req1_valid) begin
                    a_q   <= gnt1 ? req1_a : req0_a;
                    b_q   <= gnt1 ? req1_b : req0_b;
                    id_q  <= gnt1;
                    prio  <= (RR_EN != 0) & ~gnt1;
                    busy  <= 1'b1;
                    state <= CALC;
                end
                CALC: begin
                    res_sum   <= {{(RESW-OPW-1){1'b0}}, co, s};
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (res_ready) begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ADD_ARBITER_STATS_EN
    always_ff @(posedge count or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            grant_cnt0 <= grant_cnt0 + 16'(req0_ready);
            grant_cnt1 <= grant_cnt1 + 16'(req1_ready);
        end
    end
`endif
endmodule
